msrh_dcache_refill_ctrl: RTL
============================

// Module: msrh_dcache_refill_ctrl
// PURPOSE
//  Miss-handling/refill sequencer for the L1 data-cache array. Collects miss requests from the
//  LSU pipes, merges same-line misses and tracks them in ENTRY_NUM miss entries.
//  Issues line fetches to L2 under a round-robin policy. Writes returned lines into the array
//  through the array's single update port and broadcasts refill completion to the LSU pipes.
// PARAMETERS
//  REQ_NUM    2    number of LSU miss-request ports
//  ENTRY_NUM  4    miss entries (outstanding lines); ID_W = $clog2(ENTRY_NUM)
//  PADDR_W    56   physical address width
//  LINE_W     512  cache line width in bits; OFS_W = $clog2(LINE_W/8)
// PORTS
//  i_clk               in   1              clock
//  i_reset_n           in   1              asynchronous active-low reset
//  i_miss_valid        in   REQ_NUM        per-port miss request
//  i_miss_paddr        in   REQ_NUM*PADDR_W  miss address (offset bits ignored)
//  o_miss_ready        out  REQ_NUM        request accepted (allocated or merged) this cycle
//  o_miss_id           out  REQ_NUM*ID_W   entry index owning the line; valid with o_miss_ready
//  o_l2_req_valid      out  1              line fetch request
//  i_l2_req_ready      in   1              L2 accepts request
//  o_l2_req_paddr      out  PADDR_W        line-aligned address (low OFS_W bits zero)
//  o_l2_req_tag        out  ID_W           entry index
//  i_l2_resp_valid     in   1              line return
//  i_l2_resp_tag       in   ID_W           entry index of returned line
//  i_l2_resp_data      in   LINE_W         line data
//  o_dc_update_valid   out  1              array write (has priority over array reads)
//  o_dc_update_addr    out  PADDR_W        line-aligned write address
//  o_dc_update_data    out  LINE_W         write data
//  o_refill_done_valid out  1              line written; asserted in same cycle as o_dc_update_valid
//  o_refill_done_id    out  ID_W           entry completed
//  o_full              out  1              no entry in IDLE
// BEHAVIOUR
//  - Reset: all entries IDLE; every output 0, except o_full=0. Round-robin pointer=0.
//    Reset mid-operation discards all entries. Later L2 responses are ignored.
//  - Entry FSM: IDLE -> WAIT_ISSUE (allocated) -> WAIT_RESP (L2 handshake) -> WRITE (resp tag match)
//    -> IDLE (update issued). Each entry holds line address, and line data once in WRITE.
//  - Allocation: ports evaluated lowest index first, combinationally.
//    Line match against WAIT_ISSUE/WAIT_RESP entry, or entry allocated by lower port this cycle:
//    merge, ready=1, id=that entry.
//    Match against WRITE entry: ready=0; the requester replays as a read next cycle.
//    Otherwise, with no allocation yet this cycle and a free entry: allocate lowest IDLE
//    entry, ready=1. Else ready=0.
//    At most one allocation per cycle. Allocated entry is WAIT_ISSUE at next edge.
//  - L2 issue:
//    - Registered issue slot. When empty or handshaking, load the next WAIT_ISSUE entry at or
//      after the round-robin pointer.
//    - o_l2_req_* are driven from the slot and held stable while valid && !ready.
//    - On valid && ready, the entry goes to WAIT_RESP and the pointer moves past it.
//    - Earliest o_l2_req_valid is 1 cycle after allocation.
//  - Response: i_l2_resp_valid with tag of a WAIT_RESP entry captures data and moves the entry to WRITE.
//    Any other tag is ignored and flagged by an assertion.
//  - Write:
//    - The lowest-index WRITE entry drives o_dc_update_* and o_refill_done_* combinationally,
//      one line per cycle. The entry goes IDLE at that edge.
//    - Response-to-update latency is 1 cycle when no other WRITE entry exists.
//    - An entry freed this cycle is not allocatable until next cycle.
//  - Simultaneous: L2 handshake and response for different entries in one cycle are both
//    processed. Miss merge into an entry receiving its response this cycle is allowed: state
//    is WAIT_RESP at evaluation, and the requester waits for refill_done.
//  - o_full = all entries non-IDLE (registered state, not including this cycle's allocation).
// TESTING
//  - Single miss:
//    - Port0 paddr 0x1000_0040 -> ready0=1, id=0. Next cycle l2_req paddr=0x1000_0040, tag=0.
//    - Resp tag 0, data D, at cycle M -> dc_update addr 0x1000_0040, data=D, and refill_done id 0 at M+1.
//  - Merge: port0 0x2000_0000 and port1 0x2000_0010 in the same cycle -> both ready, both id=0,
//    one L2 request.
//  - Distinct same-cycle misses: port0 0x3000_0000, port1 0x4000_0000 -> ready=2'b01.
//    Port1 retried next cycle -> id=1.
//  - Full/backpressure:
//    - 4 distinct misses with i_l2_req_ready=0 -> o_full=1, 5th miss ready=0, request held stable.
//    - Raise ready -> tags issued 0,1,2,3 in round-robin order.
//  - Out-of-order responses: tags 2 and 0 in consecutive cycles -> updates for entries 2 then 0, one per cycle.
//    Stray tag 3 while entry 3 is IDLE -> no update.
//  - Reset mid-flight: assert i_reset_n=0 with 2 entries in WAIT_RESP -> all outputs 0.
//    After release, a response with tag 0 causes no update.

Source files
------------

// File: rtl/msrh_dcache_refill_ctrl.sv
// L1 data-cache miss handling and refill sequencer.
// Accepts line misses from the LSU pipes, merges misses to the same line, fetches each line
// from L2 in round-robin entry order, writes returned lines through the array update port
// and tells the LSU pipes which entry has finished.
module msrh_dcache_refill_ctrl #(
  parameter  int REQ_NUM   = 2,
  parameter  int ENTRY_NUM = 4,
  parameter  int PADDR_W   = 56,
  parameter  int LINE_W    = 512,
  localparam int ID_W      = $clog2(ENTRY_NUM),
  localparam int OFS_W     = $clog2(LINE_W / 8)
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [REQ_NUM-1:0]         i_miss_valid,
  input  logic [REQ_NUM*PADDR_W-1:0] i_miss_paddr,
  output logic [REQ_NUM-1:0]         o_miss_ready,
  output logic [REQ_NUM*ID_W-1:0]    o_miss_id,
  output logic                       o_l2_req_valid,
  input  logic                       i_l2_req_ready,
  output logic [PADDR_W-1:0]         o_l2_req_paddr,
  output logic [ID_W-1:0]            o_l2_req_tag,
  input  logic                       i_l2_resp_valid,
  input  logic [ID_W-1:0]            i_l2_resp_tag,
  input  logic [LINE_W-1:0]          i_l2_resp_data,
  output logic                       o_dc_update_valid,
  output logic [PADDR_W-1:0]         o_dc_update_addr,
  output logic [LINE_W-1:0]          o_dc_update_data,
  output logic                       o_refill_done_valid,
  output logic [ID_W-1:0]            o_refill_done_id,
  output logic                       o_full
);

  // Entries store the line address only; offset bits are implied zero.
  localparam int LINE_A_W = PADDR_W - OFS_W;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ISSUE = 2'd1,
    ST_WAIT_RESP  = 2'd2,
    ST_WRITE      = 2'd3
  } state_t;

  state_t              r_state [ENTRY_NUM];
  logic [LINE_A_W-1:0] r_addr  [ENTRY_NUM];
  logic [LINE_W-1:0]   r_data  [ENTRY_NUM];

  logic                r_slot_valid;
  logic [ID_W-1:0]     r_slot_id;
  logic [ID_W-1:0]     r_rr_ptr;

  logic [LINE_A_W-1:0]       w_req_line  [REQ_NUM];
  logic [ENTRY_NUM-1:0]      w_pend_match[REQ_NUM];
  logic [ENTRY_NUM-1:0]      w_wr_match  [REQ_NUM];
  logic [ID_W-1:0]           w_pend_id   [REQ_NUM];
  logic [REQ_NUM*OFS_W-1:0]  w_unused_ofs;

  logic                w_free_found;
  logic [ID_W-1:0]     w_free_id;
  logic                w_alloc_valid;
  logic [ID_W-1:0]     w_alloc_id;
  logic [LINE_A_W-1:0] w_alloc_line;

  logic                w_l2_hs;
  logic [ID_W-1:0]     w_search_ptr;
  logic [ENTRY_NUM-1:0] w_cand;
  logic                w_cand_found;
  logic [ID_W-1:0]     w_cand_id;

  logic [ENTRY_NUM-1:0] w_not_idle;
  logic                w_wr_valid;
  logic [ID_W-1:0]     w_wr_id;

  // Per-port line address and line comparison against every live entry.
  genvar gi, ge;
  generate
    for (gi = 0; gi < REQ_NUM; gi++) begin : g_port
      assign w_req_line[gi] = i_miss_paddr[gi*PADDR_W+OFS_W +: LINE_A_W];
      assign w_unused_ofs[gi*OFS_W +: OFS_W] = i_miss_paddr[gi*PADDR_W +: OFS_W];
      for (ge = 0; ge < ENTRY_NUM; ge++) begin : g_cmp
        assign w_pend_match[gi][ge] = ((r_state[ge] == ST_WAIT_ISSUE) || (r_state[ge] == ST_WAIT_RESP))
                                      && (r_addr[ge] == w_req_line[gi]);
        assign w_wr_match[gi][ge]   = (r_state[ge] == ST_WRITE) && (r_addr[ge] == w_req_line[gi]);
      end
    end
  endgenerate

  // Encode the pending entry that owns each port's line (at most one can match).
  always_comb begin
    for (int p = 0; p < REQ_NUM; p++) begin
      w_pend_id[p] = '0;
      for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
        if (w_pend_match[p][e]) w_pend_id[p] = ID_W'(e);
      end
    end
  end

  // Lowest IDLE entry; entries leaving WRITE this cycle are still WRITE here.
  always_comb begin
    w_free_found = 1'b0;
    w_free_id    = '0;
    for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
      if (r_state[e] == ST_IDLE) begin
        w_free_found = 1'b1;
        w_free_id    = ID_W'(e);
      end
    end
  end

  // Port arbitration, lowest port first: merge, replay on a line being written, or allocate once.
  always_comb begin
    w_alloc_valid = 1'b0;
    w_alloc_id    = '0;
    w_alloc_line  = '0;
    o_miss_ready  = '0;
    o_miss_id     = '0;
    for (int p = 0; p < REQ_NUM; p++) begin
      if (i_reset_n && i_miss_valid[p]) begin
        if (|w_pend_match[p]) begin
          o_miss_ready[p]              = 1'b1;
          o_miss_id[p*ID_W +: ID_W]    = w_pend_id[p];
        end else if (!(|w_wr_match[p])) begin
          if (w_alloc_valid) begin
            if (w_alloc_line == w_req_line[p]) begin
              o_miss_ready[p]           = 1'b1;
              o_miss_id[p*ID_W +: ID_W] = w_alloc_id;
            end
          end else if (w_free_found) begin
            w_alloc_valid             = 1'b1;
            w_alloc_id                = w_free_id;
            w_alloc_line              = w_req_line[p];
            o_miss_ready[p]           = 1'b1;
            o_miss_id[p*ID_W +: ID_W] = w_free_id;
          end
        end
      end
    end
  end

  // Issue candidates: waiting entries plus this cycle's allocation, minus the one handshaking now.
  assign w_l2_hs      = r_slot_valid && i_l2_req_ready;
  assign w_search_ptr = w_l2_hs ? (r_slot_id + ID_W'(1)) : r_rr_ptr;

  generate
    for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_cand
      assign w_cand[gi] = ((r_state[gi] == ST_WAIT_ISSUE) && !(w_l2_hs && (r_slot_id == ID_W'(gi))))
                          || (w_alloc_valid && (w_alloc_id == ID_W'(gi)));
      assign w_not_idle[gi] = (r_state[gi] != ST_IDLE);
    end
  endgenerate

  // Round-robin scan starting at the (possibly just advanced) pointer.
  always_comb begin
    w_cand_found = 1'b0;
    w_cand_id    = '0;
    for (int k = 0; k < ENTRY_NUM; k++) begin
      if (!w_cand_found && w_cand[(int'(w_search_ptr) + k) % ENTRY_NUM]) begin
        w_cand_found = 1'b1;
        w_cand_id    = ID_W'((int'(w_search_ptr) + k) % ENTRY_NUM);
      end
    end
  end

  // Issue slot: reload when empty or when the current request is accepted.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_slot_valid <= 1'b0;
      r_slot_id    <= '0;
      r_rr_ptr     <= '0;
    end else begin
      if (!r_slot_valid || w_l2_hs) begin
        r_slot_valid <= w_cand_found;
        r_slot_id    <= w_cand_id;
      end
      if (w_l2_hs) r_rr_ptr <= r_slot_id + ID_W'(1);
    end
  end

  assign o_l2_req_valid = r_slot_valid;
  assign o_l2_req_tag   = r_slot_valid ? r_slot_id : '0;
  assign o_l2_req_paddr = r_slot_valid ? {r_addr[r_slot_id], {OFS_W{1'b0}}} : '0;

  // Lowest-index WRITE entry owns the single array update port this cycle.
  always_comb begin
    w_wr_valid = 1'b0;
    w_wr_id    = '0;
    for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
      if (r_state[e] == ST_WRITE) begin
        w_wr_valid = 1'b1;
        w_wr_id    = ID_W'(e);
      end
    end
  end

  assign o_dc_update_valid   = w_wr_valid;
  assign o_dc_update_addr    = w_wr_valid ? {r_addr[w_wr_id], {OFS_W{1'b0}}} : '0;
  assign o_dc_update_data    = w_wr_valid ? r_data[w_wr_id] : '0;
  assign o_refill_done_valid = w_wr_valid;
  assign o_refill_done_id    = w_wr_id;
  assign o_full              = &w_not_idle;

  // Per-entry lifecycle: allocate, issue, capture returned line, write it back.
  generate
    for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_state[gi] <= ST_IDLE;
          r_addr[gi]  <= '0;
          r_data[gi]  <= '0;
        end else begin
          case (r_state[gi])
            ST_IDLE: begin
              if (w_alloc_valid && (w_alloc_id == ID_W'(gi))) begin
                r_state[gi] <= ST_WAIT_ISSUE;
                r_addr[gi]  <= w_alloc_line;
              end
            end
            ST_WAIT_ISSUE: begin
              if (w_l2_hs && (r_slot_id == ID_W'(gi))) r_state[gi] <= ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
              if (i_l2_resp_valid && (i_l2_resp_tag == ID_W'(gi))) begin
                r_state[gi] <= ST_WRITE;
                r_data[gi]  <= i_l2_resp_data;
              end
            end
            ST_WRITE: begin
              if (w_wr_valid && (w_wr_id == ID_W'(gi))) r_state[gi] <= ST_IDLE;
            end
            default: r_state[gi] <= ST_IDLE;
          endcase
        end
      end
    end
  endgenerate

  // Responses whose tag has no fetch outstanding are dropped; make them visible in simulation.
  always @(posedge i_clk) begin
    if (i_reset_n && i_l2_resp_valid) begin
      assert (r_state[i_l2_resp_tag] == ST_WAIT_RESP)
        else $warning("msrh_dcache_refill_ctrl: L2 response tag %0d has no outstanding fetch, dropped",
                      i_l2_resp_tag);
    end
  end

endmodule
